// File: rtl/lfsr_stream_gen.sv
// Runtime-configurable Galois LFSR pattern generator.
// Emits N-bit words on a valid/ready stream with lockup protection.
module lfsr_stream_gen #(
    parameter int LFSR_WIDTH = 16,
    parameter int LFSR_OUTPUT_BITS_PER_CLOCK = 8,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_POLY = 16'hB400,
    parameter logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'h0001
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_load,
    input  logic [LFSR_WIDTH-1:0]                 cfg_poly,
    input  logic [LFSR_WIDTH-1:0]                 cfg_seed,
    input  logic                                  init,
    input  logic                                  enable,
    output logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [LFSR_WIDTH-1:0]                 state,
    output logic                                  lockup_err,
    output logic [31:0]                           word_count
);
    localparam int W = LFSR_WIDTH;
    localparam int N = LFSR_OUTPUT_BITS_PER_CLOCK;

    logic [W-1:0]  poly_q, poly_d;
    logic [W-1:0]  seed_q, seed_d;
    logic [W-1:0]  state_q, state_d;
    logic [N-1:0]  out_q, out_d;
    logic          valid_q, valid_d;
    logic          lock_q, lock_d;
    logic [31:0]   wc_q, wc_d;

    logic [W-1:0]  chain [0:N];
    logic [N-1:0]  word;
    logic          adv;
    logic          hs;
    logic          wr;
    logic [W-1:0]  cand;

    // Unrolled stepper: chain[k] is the state before step k.
    assign chain[0] = state_q;
    for (genvar k = 0; k < N; k++) begin : g_step
        assign word[N-1-k] = chain[k][0];
        assign chain[k+1]  = (chain[k] >> 1) ^ ({W{chain[k][0]}} & poly_q);
    end

    assign adv = enable && (!valid_q || out_ready);
    assign hs  = valid_q && out_ready;

    always_comb begin
        poly_d  = poly_q;
        seed_d  = seed_q;
        state_d = state_q;
        out_d   = out_q;
        valid_d = valid_q;
        lock_d  = lock_q;
        wc_d    = wc_q + 32'(hs);
        cand    = '0;
        wr      = 1'b0;

        if (cfg_load) begin
            poly_d  = cfg_poly;
            seed_d  = cfg_seed;
            valid_d = 1'b0;
            lock_d  = 1'b0;
            cand    = cfg_seed;
            wr      = 1'b1;
        end else if (init) begin
            valid_d = 1'b0;
            cand    = seed_q;
            wr      = 1'b1;
        end else if (adv) begin
            out_d   = word;
            valid_d = 1'b1;
            cand    = chain[N];
            wr      = 1'b1;
        end else if (hs) begin
            valid_d = 1'b0;
        end

        // A zero state would stick forever; substitute 1 and flag it.
        if (wr) begin
            if (cand == '0) begin
                state_d = W'(1);
                lock_d  = 1'b1;
            end else begin
                state_d = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            poly_q  <= DEFAULT_POLY;
            seed_q  <= DEFAULT_SEED;
            state_q <= DEFAULT_SEED;
            out_q   <= '0;
            valid_q <= 1'b0;
            lock_q  <= 1'b0;
            wc_q    <= '0;
        end else begin
            poly_q  <= poly_d;
            seed_q  <= seed_d;
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            lock_q  <= lock_d;
            wc_q    <= wc_d;
        end
    end

    assign out        = out_q;
    assign out_valid  = valid_q;
    assign state      = state_q;
    assign lockup_err = lock_q;
    assign word_count = wc_q;
endmodule
